// File: rtl/sr_driver_pkg.sv
// sr_driver_pkg
//   Shared types and constants for the SR-latch driver: FSM state encoding,
//   strobe idle level, command encodings and a small max helper used to size
//   the shared phase counter.
//   Optional feature macro: SR_DRIVER_VERIFY_EN (readback states).
package sr_driver_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PULSE,
      SETTLE,
      CHECK,
      GAP
   } state_t;

   localparam logic STROBE_IDLE = 1'b1;
   localparam logic CMD_CLEAR   = 1'b0;
   localparam logic CMD_SET     = 1'b1;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sr_latch_driver_sync_2ff.sv
// sync_2ff
//   Two-flop synchronizer for one asynchronous bit; both flops reset to 0.
//   Only present in builds with SR_DRIVER_VERIFY_EN defined, since latch
//   readback is the only asynchronous input it serves.
// Ports:
//   clk   in  rising-edge clock
//   reset in  synchronous, active-high
//   d     in  asynchronous input
//   q     out synchronized output (2-cycle latency)
`ifdef SR_DRIVER_VERIFY_EN
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule
`endif

// File: rtl/sr_latch_driver.sv
// sr_latch_driver
//   Clocked driver for an external active-low SR latch. A command accepted on
//   cmd_valid & cmd_ready produces one registered low pulse on set_n (cmd_set=1)
//   or rst_n (cmd_set=0), then a done pulse, then a short gap before the next
//   command can be accepted.
//   Optional feature macro: SR_DRIVER_VERIFY_EN. When defined, a settle phase
//   and a check phase read the latch outputs back through 2-flop synchronizers
//   and report err with done. When undefined, done follows the pulse directly
//   and err is always 0.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready command handshake (ready only in IDLE)
//   cmd_set             1 = set, 0 = clear; sampled on accept
//   set_n, rst_n        active-low strobes to the latch, never low together
//   q_in, qn_in         latch outputs, asynchronous to clk
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
//   err                 readback failure, valid only with done
module sr_latch_driver
   import sr_driver_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES  = 4,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned GAP_CYCLES    = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic cmd_valid,
   output logic cmd_ready,
   input  logic cmd_set,
   output logic set_n,
   output logic rst_n,
   input  logic q_in,
   input  logic qn_in,
   output logic busy,
   output logic done,
   output logic err
);

   localparam int unsigned CNT_MAX = max3(PULSE_CYCLES, SETTLE_CYCLES, GAP_CYCLES);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   // Counter is loaded with N-1 on entry so a phase lasts exactly N cycles.
   localparam logic [CNT_W-1:0] LD_PULSE  = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(GAP_CYCLES - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_cmd;
   logic             r_ready;
   logic             r_set_n;
   logic             r_rst_n;
   logic             r_busy;
   logic             r_done;
   logic             r_err;

`ifdef SR_DRIVER_VERIFY_EN
   localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(SETTLE_CYCLES - 1);

   logic w_q_s;
   logic w_qn_s;
   logic w_err;

   sync_2ff u_sync_q  (.clk(clk), .reset(reset), .d(q_in),  .q(w_q_s));
   sync_2ff u_sync_qn (.clk(clk), .reset(reset), .d(qn_in), .q(w_qn_s));

   // Forbidden state (q==qn) or latch not holding the commanded value.
   assign w_err = (w_q_s == w_qn_s) | (w_q_s != r_cmd);
`else
   logic w_unused_rb;
   assign w_unused_rb = q_in ^ qn_in;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_cmd   <= CMD_CLEAR;
         r_ready <= 1'b0;
         r_set_n <= STROBE_IDLE;
         r_rst_n <= STROBE_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (cmd_valid && r_ready) begin
                  r_state <= PULSE;
                  r_cmd   <= cmd_set;
                  r_cnt   <= LD_PULSE;
                  r_ready <= 1'b0;
                  r_busy  <= 1'b1;
                  // Exactly one strobe is driven low, selected by the command.
                  r_set_n <= (cmd_set == CMD_SET)   ? ~STROBE_IDLE : STROBE_IDLE;
                  r_rst_n <= (cmd_set == CMD_CLEAR) ? ~STROBE_IDLE : STROBE_IDLE;
               end else begin
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            PULSE: begin
               if (r_cnt == '0) begin
                  r_set_n <= STROBE_IDLE;
                  r_rst_n <= STROBE_IDLE;
`ifdef SR_DRIVER_VERIFY_EN
                  r_state <= SETTLE;
                  r_cnt   <= LD_SETTLE;
`else
                  r_state <= CHECK;
                  r_done  <= 1'b1;
`endif
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
`ifdef SR_DRIVER_VERIFY_EN
            SETTLE: begin
               if (r_cnt == '0) begin
                  r_state <= CHECK;
                  r_done  <= 1'b1;
                  r_err   <= w_err;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
`endif
            CHECK: begin
               r_state <= GAP;
               r_cnt   <= LD_GAP;
            end
            GAP: begin
               if (r_cnt == '0) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_set_n <= STROBE_IDLE;
               r_rst_n <= STROBE_IDLE;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready = r_ready;
   assign set_n     = r_set_n;
   assign rst_n     = r_rst_n;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;

endmodule
